sprite_blitter: RTL and testbench

//  Parametrised sprite renderer for board pieces: draws one sprite from a shared

---
 rtl/sprite_pkg.sv | 19 +
 rtl/sprite_delay_line.sv | 25 ++
 rtl/sprite_blitter.sv | 112 +++++++++++
 tb/tb_sprite_blitter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite definitions: screen geometry, coordinate type, chess piece sprite ids.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef logic [9:0] coord_t;

  typedef enum logic [3:0] {
    W_PAWN, W_KNIGHT, W_BISHOP, W_ROOK, W_QUEEN, W_KING,
    B_PAWN, B_KNIGHT, B_BISHOP, B_ROOK, B_QUEEN, B_KING
  } piece_e;

  // True when a signed 11-bit offset lies in [0, len).
  function automatic logic span_hit(input logic [10:0] d, input int unsigned len);
    return !d[10] && (d < 11'(len));
  endfunction

endpackage

// File: rtl/sprite_delay_line.sv
// Reset-clearable shift register used to align side-band bits with the ROM read.
module sprite_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Draws one sprite from a shared index ROM at a per-frame (x,y) with 2**n scaling.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 55,
  parameter int SPR_H      = 55,
  parameter int NUM_SPR    = 12,
  parameter int IDX_BITS   = 2,
  parameter int SCALE_LOG2 = 0,
  parameter int ROM_LAT    = 1,
  parameter int TRANSP_IDX = 0,
  parameter int ADDR_W     = $clog2(NUM_SPR*SPR_W*SPR_H)
) (
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       blank,
  input  logic                       spr_en,
  input  logic [$clog2(NUM_SPR)-1:0] spr_id,
  input  logic [9:0]                 spr_x,
  input  logic [9:0]                 spr_y,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [IDX_BITS-1:0]        rom_q,
  output logic                       px_valid,
  output logic [IDX_BITS-1:0]        px_idx,
  output logic                       blank_o
);

  logic                       en_q;
  logic [$clog2(NUM_SPR)-1:0] id_q;
  coord_t                     x_q, y_q;

  logic [10:0]         dx, dy, tx, ty;
  logic                hit_s0;
  logic [ADDR_W-1:0]   addr_s0;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [1:0]          dl_q;
  logic                hit_d, blank_d;
  logic                px_valid_q, px_valid_d;
  logic [IDX_BITS-1:0] px_idx_q, px_idx_d;
  logic                blank_o_q;

  // Shadow registers: mid-frame input changes only land at the next frame_start.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      en_q <= 1'b0;
      id_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (frame_start) begin
      en_q <= spr_en && (int'(spr_id) < NUM_SPR);
      id_q <= spr_id;
      x_q  <= spr_x;
      y_q  <= spr_y;
    end
  end

  // Offsets are 11-bit signed, so a sprite hanging off the right/bottom edge clips.
  always_comb begin
    dx      = {1'b0, DrawX} - {1'b0, x_q};
    dy      = {1'b0, DrawY} - {1'b0, y_q};
    tx      = dx >> SCALE_LOG2;
    ty      = dy >> SCALE_LOG2;
    hit_s0  = en_q && blank
              && span_hit(dx, SPR_W << SCALE_LOG2)
              && span_hit(dy, SPR_H << SCALE_LOG2);
    addr_s0 = ADDR_W'(id_q) * ADDR_W'(SPR_W*SPR_H)
              + ADDR_W'(ty) * ADDR_W'(SPR_W)
              + ADDR_W'(tx);
  end

  // One stage for the address register plus ROM_LAT stages for the ROM itself.
  sprite_delay_line #(
    .WIDTH(2),
    .DEPTH(ROM_LAT + 1)
  ) u_align (
    .clk_i (vga_clk),
    .rst_i (reset),
    .d_i   ({hit_s0, blank}),
    .q_o   (dl_q)
  );

  assign hit_d   = dl_q[1];
  assign blank_d = dl_q[0];

  always_comb begin
    px_valid_d = hit_d && (rom_q != IDX_BITS'(TRANSP_IDX));
    px_idx_d   = px_valid_d ? rom_q : '0;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      rom_addr_q <= '0;
      px_valid_q <= 1'b0;
      px_idx_q   <= '0;
      blank_o_q  <= 1'b0;
    end else begin
      if (hit_s0) rom_addr_q <= addr_s0;
      px_valid_q <= px_valid_d;
      px_idx_q   <= px_idx_d;
      blank_o_q  <= blank_d;
    end
  end

  assign rom_addr = rom_addr_q;
  assign px_valid = px_valid_q;
  assign px_idx   = px_idx_q;
  assign blank_o  = blank_o_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: default build and a SCALE_LOG2=1 / ROM_LAT=3 build side by side.
module tb_sprite_blitter;

  logic       vga_clk = 1'b0;
  logic       reset, frame_start, blank, spr_en;
  logic [9:0] DrawX, DrawY, spr_x, spr_y;
  logic [3:0] spr_id;

  logic [15:0] addr1, addr2;
  logic [1:0]  q1, q2, r2a, r2b, i1, i2;
  logic        v1, v2, bo1, bo2;

  always #5 vga_clk = ~vga_clk;

  // ROM models: contents are addr[1:0]; latency 1 for dut1, 3 for dut2.
  always @(posedge vga_clk) begin
    q1  <= addr1[1:0];
    r2a <= addr2[1:0];
    r2b <= r2a;
    q2  <= r2b;
  end

  sprite_blitter dut1 (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .spr_en(spr_en),
    .spr_id(spr_id), .spr_x(spr_x), .spr_y(spr_y), .rom_addr(addr1),
    .rom_q(q1), .px_valid(v1), .px_idx(i1), .blank_o(bo1)
  );

  sprite_blitter #(.SCALE_LOG2(1), .ROM_LAT(3)) dut2 (
    .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .spr_en(spr_en),
    .spr_id(spr_id), .spr_x(spr_x), .spr_y(spr_y), .rom_addr(addr2),
    .rom_q(q2), .px_valid(v2), .px_idx(i2), .blank_o(bo2)
  );

  typedef struct {
    bit hit;
    int addr;
    bit valid;
    int idx;
    bit blank;
  } exp_t;

  exp_t h1[$], h2[$];
  int   last1, last2;
  bit   m_en;
  int   m_id, m_x, m_y;
  int   checks = 0, failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: which texel of which sprite sits under this pixel, from plain arithmetic.
  function automatic exp_t model(input int s_log2);
    exp_t e;
    int s  = 1 << s_log2;
    int dx = int'(DrawX) - m_x;
    int dy = int'(DrawY) - m_y;
    e.hit   = m_en && blank && dx >= 0 && dx < 55*s && dy >= 0 && dy < 55*s;
    e.addr  = e.hit ? m_id*3025 + (dy/s)*55 + dx/s : 0;
    e.idx   = e.addr % 4;
    e.valid = e.hit && e.idx != 0;
    if (!e.valid) e.idx = 0;
    e.blank = blank;
    return e;
  endfunction

  // Called just after a negedge with inputs already driven; returns after the next negedge.
  task automatic tick();
    exp_t z, e1, e2;
    z = '{0, 0, 0, 0, 0};
    if (reset) begin
      h1 = {};
      h2 = {};
      for (int i = 0; i < 3; i++) h1.push_back(z);
      for (int i = 0; i < 5; i++) h2.push_back(z);
      last1 = 0; last2 = 0;
      m_en = 0; m_id = 0; m_x = 0; m_y = 0;
    end else begin
      e1 = model(0);
      e2 = model(1);
      h1.push_front(e1); void'(h1.pop_back());
      h2.push_front(e2); void'(h2.pop_back());
      if (e1.hit) last1 = e1.addr;
      if (e2.hit) last2 = e2.addr;
      if (frame_start) begin
        m_en = spr_en && spr_id < 12;
        m_id = int'(spr_id);
        m_x  = int'(spr_x);
        m_y  = int'(spr_y);
      end
    end
    @(posedge vga_clk);
    #1;
    check("d1_rom_addr", addr1, last1);
    check("d1_px_valid", v1, h1[2].valid);
    check("d1_px_idx",   i1, h1[2].idx);
    check("d1_blank_o",  bo1, h1[2].blank);
    check("d2_rom_addr", addr2, last2);
    check("d2_px_valid", v2, h2[4].valid);
    check("d2_px_idx",   i2, h2[4].idx);
    check("d2_blank_o",  bo2, h2[4].blank);
    @(negedge vga_clk);
  endtask

  task automatic pix(input int x, input int y, input bit b);
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    tick();
  endtask

  task automatic set_frame(input bit en, input int id, input int x, input int y);
    frame_start = 1'b1; spr_en = en; spr_id = 4'(id); spr_x = 10'(x); spr_y = 10'(y);
    pix(0, 0, 1'b0);
    frame_start = 1'b0;
  endtask

  typedef struct {
    int x; int y; bit b;
    int e_addr; bit e_valid; int e_idx;
  } vec_t;

  vec_t tv[12];

  initial begin
    tv[0]  = '{100,  50, 1,    0, 0, 0};
    tv[1]  = '{101,  50, 1,    1, 1, 1};
    tv[2]  = '{102,  50, 1,    2, 1, 2};
    tv[3]  = '{103,  50, 1,    3, 1, 3};
    tv[4]  = '{104,  51, 1,   59, 1, 3};
    tv[5]  = '{154, 104, 1, 3024, 0, 0};
    tv[6]  = '{155,  50, 1, 3024, 0, 0};
    tv[7]  = '{ 99,  50, 1, 3024, 0, 0};
    tv[8]  = '{100,  49, 1, 3024, 0, 0};
    tv[9]  = '{101,  50, 0, 3024, 0, 0};
    tv[10] = '{130,  60, 1,  580, 0, 0};
    tv[11] = '{131,  60, 1,  581, 1, 1};

    reset = 1'b1; frame_start = 1'b0; blank = 1'b0; spr_en = 1'b0;
    spr_id = '0; spr_x = '0; spr_y = '0; DrawX = '0; DrawY = '0;
    @(negedge vga_clk);
    tick(); tick();
    check("reset_rom_addr", addr1, 0);
    check("reset_px_valid", v1, 0);
    reset = 1'b0;
    tick();

    // Directed table: sprite 0 at (100,50)
    set_frame(1'b1, 0, 100, 50);
    foreach (tv[k]) begin
      pix(tv[k].x, tv[k].y, tv[k].b);
      check("tbl_rom_addr", addr1, tv[k].e_addr);
      pix(0, 0, 1'b0);
      pix(0, 0, 1'b0);
      check("tbl_px_valid", v1, tv[k].e_valid);
      check("tbl_px_idx", i1, tv[k].e_idx);
      check("tbl_blank_o", bo1, tv[k].b);
    end

    // Async reset mid-line while an opaque pixel is in flight
    for (int k = 0; k < 4; k++) pix(101, 50, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_async_px_valid", v1, 0);
    check("rst_async_px_idx", i1, 0);
    check("rst_async_blank_o", bo1, 0);
    check("rst_async_d2_valid", v2, 0);
    @(negedge vga_clk);
    for (int k = 0; k < 3; k++) pix(101, 50, 1'b1);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) pix(101, 50, 1'b1);
    check("rst_nodraw_px_valid", v1, 0);
    check("rst_nodraw_d2_valid", v2, 0);

    // Clip at bottom-right corner
    set_frame(1'b1, 0, 620, 470);
    for (int y = 469; y < 480; y++) begin
      for (int x = 600; x < 640; x++) pix(x, y, 1'b1);
      for (int x = 0; x < 6; x++) pix(x, y, 1'b1);
    end
    pix(639, 479, 1'b1);
    check("clip_corner_addr", addr1, 514);

    // Scaled build addressing
    set_frame(1'b1, 0, 0, 0);
    pix(2, 3, 1'b1);
    check("scale_addr_d2", addr2, 56);
    check("scale_addr_d1", addr1, 167);

    // Shadowing: mid-frame changes ignored until frame_start
    set_frame(1'b1, 0, 100, 50);
    spr_x = 10'd200; spr_id = 4'd3;
    pix(101, 50, 1'b1);
    check("shadow_hold_addr", addr1, 1);
    set_frame(1'b1, 3, 200, 50);
    pix(200, 50, 1'b1);
    check("shadow_id3_addr", addr1, 9075);
    set_frame(1'b1, 12, 200, 50);
    for (int k = 0; k < 10; k++) pix(201 + k, 51, 1'b1);
    check("id12_px_valid", v1, 0);
    check("id12_addr_held", addr1, 9075);

    // Randomised stream
    for (int n = 0; n < 3000; n++) begin
      frame_start = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) begin
        spr_en = ($urandom_range(0, 3) != 0);
        spr_id = 4'($urandom_range(0, 13));
        spr_x  = 10'($urandom_range(0, 700));
        spr_y  = 10'($urandom_range(0, 520));
      end
      reset = ($urandom_range(0, 799) == 0);
      pix((m_x + $urandom_range(0, 130) - 10) & 10'h3FF,
          (m_y + $urandom_range(0, 130) - 10) & 10'h3FF,
          $urandom_range(0, 7) != 0);
      reset = 1'b0;
      frame_start = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
